// File: rtl/univ_register_if.sv
// Bus bundle for univ_register: control, parallel/serial data in, register
// contents and status flags out.
interface univ_register_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] I;
    logic             sin_r;
    logic             sin_l;
    logic [WIDTH-1:0] R;
    logic             carry;
    logic             zero;

    // Controller side: drives operations, observes the register.
    modport master (
        output en, mode, I, sin_r, sin_l,
        input  R, carry, zero
    );

    // Register side.
    modport slave (
        input  en, mode, I, sin_r, sin_l,
        output R, carry, zero
    );
endinterface

// File: rtl/univ_register.sv
// Universal WIDTH-bit register: hold, load, shift left/right, rotate left,
// increment, decrement and synchronous clear, with a registered
// carry/borrow/shift-out flag and a combinational zero flag.
// WIDTH must be at least 2 so that R[WIDTH-2:0] is a real slice.
module univ_register #(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic            clock,
    input  logic            reset,
    univ_register_if.slave  bus
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_INC  = 3'b100;
    localparam logic [2:0] MODE_DEC  = 3'b101;
    localparam logic [2:0] MODE_ROL  = 3'b110;
    localparam logic [2:0] MODE_CLR  = 3'b111;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_value;
    logic             r_carry;
    logic [WIDTH-1:0] w_next_value;
    logic             w_next_carry;

    // True when every bit of the operand is set (INC overflow condition).
    function automatic logic all_ones(input logic [WIDTH-1:0] v);
        return &v;
    endfunction

    // True when the operand is zero (DEC borrow condition, zero flag).
    function automatic logic all_zero(input logic [WIDTH-1:0] v);
        return ~|v;
    endfunction

    // Next-state decode: selected operation on current R, or hold when disabled.
    always_comb begin
        w_next_value = r_value;
        w_next_carry = r_carry;
        if (bus.en) begin
            case (bus.mode)
                MODE_HOLD: begin
                    w_next_value = r_value;
                    w_next_carry = r_carry;
                end
                MODE_LOAD: begin
                    w_next_value = bus.I;
                    w_next_carry = 1'b0;
                end
                MODE_SHL: begin
                    w_next_value = {r_value[WIDTH-2:0], bus.sin_r};
                    w_next_carry = r_value[WIDTH-1];
                end
                MODE_SHR: begin
                    w_next_value = {bus.sin_l, r_value[WIDTH-1:1]};
                    w_next_carry = r_value[0];
                end
                MODE_INC: begin
                    w_next_value = r_value + ONE;
                    w_next_carry = all_ones(r_value);
                end
                MODE_DEC: begin
                    w_next_value = r_value - ONE;
                    w_next_carry = all_zero(r_value);
                end
                MODE_ROL: begin
                    w_next_value = {r_value[WIDTH-2:0], r_value[WIDTH-1]};
                    w_next_carry = r_value[WIDTH-1];
                end
                MODE_CLR: begin
                    w_next_value = '0;
                    w_next_carry = 1'b0;
                end
                default: begin
                    w_next_value = r_value;
                    w_next_carry = r_carry;
                end
            endcase
        end else begin
            w_next_value = r_value;
            w_next_carry = r_carry;
        end
    end

    // State register: async reset to RESET_VALUE with carry cleared.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_value <= RESET_VALUE;
            r_carry <= 1'b0;
        end else begin
            r_value <= w_next_value;
            r_carry <= w_next_carry;
        end
    end

    // R and carry come straight from flops; zero is decoded from R with no
    // added latency so the controller sees it in the same cycle.
    assign bus.R     = r_value;
    assign bus.carry = r_carry;
    assign bus.zero  = all_zero(r_value);

endmodule

// File: tb/tb_univ_register.sv
// Self-checking bench for univ_register: three instances (WIDTH 4/8/2) driven
// with common stimulus; expected state is pushed to a scoreboard queue when a
// step is driven and popped/compared one edge later.
module tb_univ_register;

    localparam logic [2:0] HOLD = 3'b000;
    localparam logic [2:0] LOAD = 3'b001;
    localparam logic [2:0] SHL  = 3'b010;
    localparam logic [2:0] SHR  = 3'b011;
    localparam logic [2:0] INC  = 3'b100;
    localparam logic [2:0] DEC  = 3'b101;
    localparam logic [2:0] ROL  = 3'b110;
    localparam logic [2:0] CLR  = 3'b111;

    typedef struct {
        logic [7:0] r;
        logic       c;
    } exp_t;

    logic clock;
    logic reset;
    int   total;
    int   bad;

    exp_t       sb[$];
    logic [7:0] mr [3];
    logic       mc [3];
    int         wd [3];
    logic [7:0] rv [3];

    univ_register_if #(.WIDTH(4)) if4 ();
    univ_register_if #(.WIDTH(8)) if8 ();
    univ_register_if #(.WIDTH(2)) if2 ();

    univ_register #(.WIDTH(4), .RESET_VALUE(4'hA)) dut4 (
        .clock (clock), .reset (reset), .bus (if4)
    );
    univ_register #(.WIDTH(8), .RESET_VALUE(8'h00)) dut8 (
        .clock (clock), .reset (reset), .bus (if8)
    );
    univ_register #(.WIDTH(2), .RESET_VALUE(2'b11)) dut2 (
        .clock (clock), .reset (reset), .bus (if2)
    );

    // Free-running clock, 10 time units per period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural reference: next {carry, R} for a width-w register.
    function automatic logic [8:0] model_next(input int w, input logic [7:0] r,
                                              input logic c, input logic e,
                                              input logic [2:0] m, input logic [7:0] d,
                                              input logic sl, input logic sr);
        logic [7:0] mask;
        logic       msb;
        logic [7:0] nr;
        logic       nc;
        mask = 8'((9'd1 << w) - 9'd1);
        msb  = r[w-1];
        nr   = r;
        nc   = c;
        if (e) begin
            case (m)
                LOAD: begin nr = d & mask; nc = 1'b0; end
                SHL:  begin nr = ((r << 1) | {7'd0, sr}) & mask; nc = msb; end
                SHR:  begin nr = (r >> 1) | ({7'd0, sl} << (w - 1)); nc = r[0]; end
                INC:  begin nr = (r + 8'd1) & mask; nc = (r == mask); end
                DEC:  begin nr = (r - 8'd1) & mask; nc = (r == 8'd0); end
                ROL:  begin nr = ((r << 1) | {7'd0, msb}) & mask; nc = msb; end
                CLR:  begin nr = 8'd0; nc = 1'b0; end
                default: begin nr = r; nc = c; end
            endcase
        end
        return {nc, nr};
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pop one expectation per instance and compare R, carry and zero.
    task automatic compare_all(input string tag);
        exp_t       e;
        logic [7:0] r_obs;
        logic       c_obs;
        logic       z_obs;
        for (int k = 0; k < 3; k++) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $error("FAIL %s scoreboard_empty observed=0 expected=1", tag);
            end else begin
                e = sb.pop_front();
                case (k)
                    0:       begin r_obs = 8'(if4.R); c_obs = if4.carry; z_obs = if4.zero; end
                    1:       begin r_obs = if8.R;     c_obs = if8.carry; z_obs = if8.zero; end
                    default: begin r_obs = 8'(if2.R); c_obs = if2.carry; z_obs = if2.zero; end
                endcase
                check($sformatf("%s_w%0d_R", tag, wd[k]), r_obs, e.r);
                check($sformatf("%s_w%0d_carry", tag, wd[k]), {7'd0, c_obs}, {7'd0, e.c});
                check($sformatf("%s_w%0d_zero", tag, wd[k]), {7'd0, z_obs}, {7'd0, e.r == 8'd0});
            end
        end
    endtask

    task automatic drive(input logic e, input logic [2:0] m, input logic [7:0] d,
                         input logic sl, input logic sr);
        if4.en = e; if4.mode = m; if4.I = d[3:0]; if4.sin_l = sl; if4.sin_r = sr;
        if8.en = e; if8.mode = m; if8.I = d;      if8.sin_l = sl; if8.sin_r = sr;
        if2.en = e; if2.mode = m; if2.I = d[1:0]; if2.sin_l = sl; if2.sin_r = sr;
    endtask

    // One operation: drive, predict, wait one edge, compare.
    task automatic step(input string tag, input logic e, input logic [2:0] m,
                        input logic [7:0] d, input logic sl, input logic sr);
        logic [8:0] nx;
        drive(e, m, d, sl, sr);
        for (int k = 0; k < 3; k++) begin
            nx    = model_next(wd[k], mr[k], mc[k], e, m, d, sl, sr);
            mr[k] = nx[7:0];
            mc[k] = nx[8];
            sb.push_back('{r: mr[k], c: mc[k]});
        end
        @(posedge clock);
        #1;
        compare_all(tag);
    endtask

    // Model takes reset values; expectations queued for the next compare.
    task automatic expect_reset();
        for (int k = 0; k < 3; k++) begin
            mr[k] = rv[k];
            mc[k] = 1'b0;
            sb.push_back('{r: mr[k], c: mc[k]});
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        wd[0] = 4;     wd[1] = 8;     wd[2] = 2;
        rv[0] = 8'h0A; rv[1] = 8'h00; rv[2] = 8'h03;
        reset = 1'b0;
        drive(1'b0, HOLD, 8'h00, 1'b0, 1'b0);

        // Power-up reset.
        @(posedge clock);
        #1;
        expect_reset();
        compare_all("por");
        reset = 1'b1;

        // Some activity, then reset asserted mid-operation with INC selected.
        step("pre_load", 1'b1, LOAD, 8'h35, 1'b0, 1'b0);
        step("pre_inc", 1'b1, INC, 8'h00, 1'b0, 1'b0);
        drive(1'b1, INC, 8'h00, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        expect_reset();
        compare_all("rst_async");
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            expect_reset();
            compare_all("rst_hold");
        end
        reset = 1'b1;
        step("post_rst_load", 1'b1, LOAD, 8'h03, 1'b0, 1'b0);

        // LOAD, disabled LOADs, then HOLD.
        step("load5", 1'b1, LOAD, 8'h05, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("en_off", 1'b0, LOAD, 8'hFF, 1'b1, 1'b1);
        step("hold", 1'b1, HOLD, 8'hFF, 1'b1, 1'b1);

        // Wrap-around: FE is all-ones-minus-one at every width.
        step("wrap_load", 1'b1, LOAD, 8'hFE, 1'b0, 1'b0);
        step("wrap_inc1", 1'b1, INC, 8'h00, 1'b0, 1'b0);
        step("wrap_inc2", 1'b1, INC, 8'h00, 1'b0, 1'b0);
        step("wrap_dec1", 1'b1, DEC, 8'h00, 1'b0, 1'b0);
        step("wrap_dec2", 1'b1, DEC, 8'h00, 1'b0, 1'b0);

        // Shifts and rotate.
        step("sh_load", 1'b1, LOAD, 8'h09, 1'b0, 1'b0);
        step("shl", 1'b1, SHL, 8'hFF, 1'b1, 1'b0);
        step("shr", 1'b1, SHR, 8'hFF, 1'b1, 1'b0);
        step("rol", 1'b1, ROL, 8'hFF, 1'b0, 1'b1);

        // Synchronous clear after counting to overflow (4-bit: 9 INCs from 7).
        step("clr_load", 1'b1, LOAD, 8'h07, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) step("clr_inc", 1'b1, INC, 8'h00, 1'b0, 1'b0);
        step("clr", 1'b1, CLR, 8'hFF, 1'b1, 1'b1);

        // Random mix of modes, enables, data and serial inputs.
        for (int i = 0; i < 1000; i++) begin
            step("rand", ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
